pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Fetch-stage PC sequencer and IF/ID pipeline register; consumes PCBranchD from the decode-stage
//  branch-target adder and closes the PC loop. Holds PCF, drives instruction memory, produces
//  PC_Plus1D for the adder, flushes the wrong-path instruction on a taken branch, and
//  supports stall and halt. Imem read is combinational: InstrF is valid in the same cycle as PCF.
// PARAMETERS
//  PC_W     7   PC / branch-target width; all PC arithmetic is modulo 2**PC_W
//  INSTR_W  16  instruction width
//  CNT_W    8   width of delivered-instruction counter
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  StallF      in   1        hazard unit: hold PCF
//  StallD      in   1        hazard unit: hold IF/ID register
//  PCSrcD      in   1        taken branch resolved in decode
//  PCBranchD   in   PC_W     branch target (PC_Plus1D + sign-extended offset)
//  HaltD       in   1        decoded instruction in D is HALT
//  InstrF      in   INSTR_W  imem read data at PCF
//  PCF         out  PC_W     fetch PC / imem address
//  InstrD      out  INSTR_W  IF/ID instruction
//  PC_Plus1D   out  PC_W     IF/ID copy of PCF+1
//  ValidD      out  1        InstrD is a real instruction (0 = bubble)
//  Halted      out  1        FSM in HALTED
//  FetchCount  out  CNT_W    instructions delivered to D, saturating
// BEHAVIOUR
//  Reset (async, immediate, any state): PCF=0, InstrD=0, PC_Plus1D=0, ValidD=0, Halted=0,
//   FetchCount=0, state=BOOT.
//  FSM states BOOT -> RUN -> HALTED; HALTED exits only via rst_n.
//  BOOT: one cycle; PCF held at 0, IF/ID loads bubble; unconditionally -> RUN.
//  RUN, per rising edge:
//   halt    = ValidD & HaltD & ~StallD
//   redirect = PCSrcD & ~StallD & ~halt     (HaltD beats PCSrcD; PCSrcD ignored while StallD=1)
//   PCF:   halt -> hold; redirect -> PCBranchD (overrides StallF); else ~StallF -> PCF+1; else hold
//   IF/ID: halt or redirect -> bubble (InstrD=0, ValidD=0, PC_Plus1D=0);
//          else ~StallD -> InstrD=InstrF, PC_Plus1D=PCF+1, ValidD=1; else hold all three
//   halt -> state HALTED.
//  HALTED: PCF frozen, IF/ID loads bubble every cycle, Halted=1, all inputs ignored.
//  Latency: PCF -> InstrD/PC_Plus1D one cycle; taken branch costs exactly one bubble.
//  Width: PCF+1 wraps 2**PC_W-1 -> 0 (127 -> 0 at defaults); PC_Plus1D likewise; no carry out.
//  FetchCount: +1 on every edge that loads ValidD=1 from InstrF; saturates at 2**CNT_W-1.
//  StallF=1 & StallD=0 without redirect: D loads InstrF again (duplicate is hazard unit's concern).
// TESTING
//  Reset release, StallF=StallD=PCSrcD=0: cycle1 PCF=0 ValidD=0 (BOOT); then PCF=1,2,3;
//   InstrD=mem[0], PC_Plus1D=1, ValidD=1 one cycle after PCF=0 is fetched in RUN.
//  PCF=5, PCSrcD=1, PCBranchD=20 -> next edge PCF=20, ValidD=0, InstrD=0; next edge InstrD=mem[20],
//   PC_Plus1D=21; FetchCount not incremented for the bubble.
//  StallF=1,StallD=1 for 3 cycles at PCF=9 -> PCF, InstrD, PC_Plus1D, ValidD, FetchCount unchanged;
//   PCSrcD=1 during stall ignored; release -> PCF=10.
//  PCF=127 sequential -> PCF=0, PC_Plus1D=0 (wrap); PCBranchD=0x7F taken -> PCF=127.
//  ValidD=1,HaltD=1,PCSrcD=1 -> Halted=1, PCF frozen, ValidD=0 thereafter; rst_n pulse low
//   mid-HALTED -> all outputs zero immediately, BOOT then RUN from PC 0.
//  260 sequential fetches with CNT_W=8 -> FetchCount sticks at 255.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC sequencer plus IF/ID pipeline register with a BOOT/RUN/HALTED FSM.
// Latency: PCF -> InstrD/PC_Plus1D is one cycle; a taken branch costs exactly one bubble.
// Backpressure: StallF holds PCF and StallD holds IF/ID; a redirect beats StallF; HALTED ignores all inputs.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   StallF, StallD              hazard-unit stalls for fetch and decode
//   PCSrcD, PCBranchD           taken branch and its target, resolved in decode
//   HaltD                       instruction in decode is HALT
//   InstrF                      combinational imem read data at PCF
//   PCF                         fetch PC / imem address
//   InstrD, PC_Plus1D, ValidD   IF/ID register contents (ValidD=0 marks a bubble)
//   Halted                      FSM is in HALTED
//   FetchCount                  saturating count of instructions delivered to decode
module pc_fetch_unit #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [PC_W-1:0]    PCBranchD,
  input  logic               HaltD,
  input  logic [INSTR_W-1:0] InstrF,
  output logic [PC_W-1:0]    PCF,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PC_Plus1D,
  output logic               ValidD,
  output logic               Halted,
  output logic [CNT_W-1:0]   FetchCount
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      pc_plus1_q, pc_plus1_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 halt;
  logic                 redirect;
  logic                 load_f;
  logic [PC_W-1:0]      pc_inc;

  // Natural-width add: wraps modulo 2**PC_W with no carry out.
  assign pc_inc = pc_q + PC_ONE;

  // Halt only counts for a real instruction that is actually advancing out of
  // decode; a halting instruction also suppresses a branch resolved with it.
  assign halt     = (state_q == ST_RUN) && valid_q && HaltD && !StallD;
  assign redirect = (state_q == ST_RUN) && PCSrcD && !StallD && !halt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    load_f     = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        pc_d       = '0;
        instr_d    = '0;
        pc_plus1_d = '0;
        valid_d    = 1'b0;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          instr_d    = '0;
          pc_plus1_d = '0;
          valid_d    = 1'b0;
          state_d    = ST_HALTED;
        end else if (redirect) begin
          // Redirect wins over StallF; the wrong-path fetch becomes a bubble.
          pc_d       = PCBranchD;
          instr_d    = '0;
          pc_plus1_d = '0;
          valid_d    = 1'b0;
        end else begin
          if (!StallF) begin
            pc_d = pc_inc;
          end
          if (!StallD) begin
            instr_d    = InstrF;
            pc_plus1_d = pc_inc;
            valid_d    = 1'b1;
            load_f     = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        instr_d    = '0;
        pc_plus1_d = '0;
        valid_d    = 1'b0;
      end
      default: begin
        pc_d       = '0;
        instr_d    = '0;
        pc_plus1_d = '0;
        valid_d    = 1'b0;
        state_d    = ST_BOOT;
      end
    endcase

    halted_d = (state_d == ST_HALTED);
    cnt_d    = (load_f && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= '0;
      instr_q    <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign PCF        = pc_q;
  assign InstrD     = instr_q;
  assign PC_Plus1D  = pc_plus1_q;
  assign ValidD     = valid_q;
  assign Halted     = halted_q;
  assign FetchCount = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a cycle model predicts every output per edge into a scoreboard queue.
// Latency: expectation pushed when an edge's stimulus is driven, popped 1ns after that edge.
// Backpressure: stall/redirect/halt patterns are driven from directed sequences plus a random phase.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        StallF, StallD, PCSrcD, HaltD;
  logic [6:0]  PCBranchD;
  logic [15:0] InstrF;
  logic [6:0]  PCF;
  logic [15:0] InstrD;
  logic [6:0]  PC_Plus1D;
  logic        ValidD, Halted;
  logic [7:0]  FetchCount;

  logic [15:0] mem [0:127];

  pc_fetch_unit #(.PC_W(7), .INSTR_W(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .StallD     (StallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .HaltD      (HaltD),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PC_Plus1D  (PC_Plus1D),
    .ValidD     (ValidD),
    .Halted     (Halted),
    .FetchCount (FetchCount)
  );

  // Combinational instruction memory.
  assign InstrF = mem[PCF];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  pc;
    logic [15:0] instr;
    logic [6:0]  pp1;
    logic        valid;
    logic        halted;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state (0 = BOOT, 1 = RUN, 2 = HALTED).
  int          m_state;
  logic [6:0]  m_pc;
  logic [15:0] m_instr;
  logic [6:0]  m_pp1;
  logic        m_valid;
  logic        m_halted;
  logic [7:0]  m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_pc     = '0;
    m_instr  = '0;
    m_pp1    = '0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_cnt    = '0;
  endtask

  task automatic model_bubble();
    m_instr = '0;
    m_pp1   = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic sf, input logic sd, input logic ps,
                            input logic [6:0] br, input logic hd);
    logic h, r;
    case (m_state)
      0: begin
        m_pc = '0;
        model_bubble();
        m_state = 1;
      end
      1: begin
        h = m_valid & hd & ~sd;
        r = ps & ~sd & ~h;
        if (h) begin
          model_bubble();
          m_state = 2;
        end else if (r) begin
          model_bubble();
          m_pc = br;
        end else begin
          if (!sd) begin
            m_instr = mem[m_pc];
            m_pp1   = m_pc + 7'd1;
            m_valid = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          end
          if (!sf) m_pc = m_pc + 7'd1;
        end
      end
      default: model_bubble();
    endcase
    m_halted = (m_state == 2);
  endtask

  task automatic compare_all(input exp_t e);
    check_eq("pcf",    32'(PCF),        32'(e.pc));
    check_eq("instrd", 32'(InstrD),     32'(e.instr));
    check_eq("pp1d",   32'(PC_Plus1D),  32'(e.pp1));
    check_eq("validd", 32'(ValidD),     32'(e.valid));
    check_eq("halted", 32'(Halted),     32'(e.halted));
    check_eq("fcnt",   32'(FetchCount), 32'(e.cnt));
  endtask

  // One clock edge: drive, predict, push; then pop and compare after the edge.
  task automatic step(input logic sf, input logic sd, input logic ps,
                      input logic [6:0] br, input logic hd);
    exp_t e;
    StallF    = sf;
    StallD    = sd;
    PCSrcD    = ps;
    PCBranchD = br;
    HaltD     = hd;
    model_edge(sf, sd, ps, br, hd);
    e.pc = m_pc; e.instr = m_instr; e.pp1 = m_pp1;
    e.valid = m_valid; e.halted = m_halted; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      compare_all(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_pcf"},    32'(PCF),        32'd0);
    check_eq({tag, "_instrd"}, 32'(InstrD),     32'd0);
    check_eq({tag, "_pp1d"},   32'(PC_Plus1D),  32'd0);
    check_eq({tag, "_validd"}, 32'(ValidD),     32'd0);
    check_eq({tag, "_halted"}, 32'(Halted),     32'd0);
    check_eq({tag, "_fcnt"},   32'(FetchCount), 32'd0);
  endtask

  // Hard stop in case the run never reaches its summary.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cnt_before;
    logic [6:0] pc_frozen;

    for (int i = 0; i < 128; i++) mem[i] = 16'h8000 | 16'(i * 37);

    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
    PCBranchD = '0; HaltD = 1'b0;
    model_reset();

    #12;
    check_zero_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // BOOT edge then sequential fetch from 0.
    step(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    check_eq("boot_pcf",   32'(PCF),    32'd0);
    check_eq("boot_valid", 32'(ValidD), 32'd0);
    step(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    check_eq("first_instr", 32'(InstrD),    32'(mem[0]));
    check_eq("first_pp1",   32'(PC_Plus1D), 32'd1);
    idle(4);
    check_eq("seq_pcf5", 32'(PCF), 32'd5);

    // Taken branch from PC 5 to 20.
    cnt_before = FetchCount;
    step(1'b0, 1'b0, 1'b1, 7'd20, 1'b0);
    check_eq("br_pcf",   32'(PCF),        32'd20);
    check_eq("br_valid", 32'(ValidD),     32'd0);
    check_eq("br_cnt",   32'(FetchCount), 32'(cnt_before));
    step(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    check_eq("br_instr", 32'(InstrD),    32'(mem[20]));
    check_eq("br_pp1",   32'(PC_Plus1D), 32'd21);

    // Reach PC 9, then stall both stages for 3 cycles with an ignored branch.
    step(1'b0, 1'b0, 1'b1, 7'd8, 1'b0);
    step(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    check_eq("pre_stall_pcf", 32'(PCF), 32'd9);
    cnt_before = FetchCount;
    step(1'b1, 1'b1, 1'b0, 7'd0,  1'b0);
    step(1'b1, 1'b1, 1'b1, 7'd50, 1'b0);
    step(1'b1, 1'b1, 1'b0, 7'd0,  1'b0);
    check_eq("stall_pcf", 32'(PCF),        32'd9);
    check_eq("stall_cnt", 32'(FetchCount), 32'(cnt_before));
    step(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    check_eq("unstall_pcf", 32'(PCF), 32'd10);

    // Randomised stalls and branches, no halt.
    for (int k = 0; k < 80; k++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), 7'($urandom_range(0, 127)), 1'b0);
    end

    // PC wrap 127 -> 0, then branch to 0x7F.
    step(1'b0, 1'b0, 1'b1, 7'd126, 1'b0);
    idle(2);
    check_eq("wrap_pcf", 32'(PCF),       32'd0);
    check_eq("wrap_pp1", 32'(PC_Plus1D), 32'd0);
    step(1'b0, 1'b0, 1'b1, 7'h7F, 1'b0);
    check_eq("br7f_pcf", 32'(PCF), 32'd127);

    // Halt beats a simultaneous branch.
    idle(1);
    pc_frozen = PCF;
    step(1'b0, 1'b0, 1'b1, 7'd40, 1'b1);
    check_eq("halt_flag", 32'(Halted), 32'd1);
    check_eq("halt_pcf",  32'(PCF),    32'(pc_frozen));
    for (int k = 0; k < 4; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    end
    check_eq("halted_pcf",   32'(PCF),    32'(pc_frozen));
    check_eq("halted_valid", 32'(ValidD), 32'd0);

    // Asynchronous reset mid-HALTED.
    rst_n = 1'b0;
    #2;
    check_zero_outputs("arst");
    model_reset();
    @(posedge clk); #1;
    check_zero_outputs("arst_hold");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    check_eq("reboot_pcf", 32'(PCF), 32'd0);
    step(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    check_eq("rerun_pcf", 32'(PCF), 32'd1);

    // FetchCount saturation.
    idle(262);
    check_eq("cnt_sat", 32'(FetchCount), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
